or4_rr_grant: RTL and testbench
===============================

Name: or4_rr_grant

Overview:
- Return-path companion to the 4-input OR request combiner.
- The combiner collapses four requesters into one "any request" line. This block returns a registered one-hot grant to exactly one of those four requesters, using round-robin priority.
- It also supplies a registered ANY flag that is equivalent to the combiner's output.
- It sits between the four request sources and the shared resource they contend for.

Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles a requester keeps the grant while others are waiting. 0 means unlimited hold.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- REQ  input  4  request lines; bit i = requester i; level-sensitive.
- GNT  output 4  one-hot grant, registered; all-zero when idle.
- GNT_ID  output 2  index of current grant owner; holds last owner when idle.
- BUSY  output 1  high while any GNT bit is set.
- ANY  output 1  registered OR of REQ[3:0], 1-cycle latency.

Behaviour:
- Reset, sampled on a CLK edge with RST=1:
  - GNT=0, GNT_ID=0, BUSY=0, ANY=0.
  - Priority pointer PTR=0, hold counter HCNT=0, state=IDLE.
  - RST overrides all other inputs.
  - Reset during a grant clears GNT on that same edge.
- ANY: registered each edge as REQ[0]|REQ[1]|REQ[2]|REQ[3]. Independent of arbitration state.
- States: IDLE, GRANT.
- IDLE:
  - If REQ≠0, choose the first set bit scanning circularly PTR, PTR+1, PTR+2, PTR+3 (mod 4).
  - On the next edge: GNT=onehot(winner), GNT_ID=winner, BUSY=1, HCNT=1, state→GRANT.
  - Latency from REQ sampled to GNT visible is 1 cycle.
  - If REQ=0, remain in IDLE with outputs unchanged.
- GRANT (owner o):
  - Normal release: if REQ[o]=0 at an edge, then GNT=0, BUSY=0, PTR=(o+1) mod 4, state→IDLE on that edge.
    - This forces exactly one dead cycle, so the minimum gap between grants is 1 cycle.
  - Forced release: if MAX_HOLD≠0, HCNT==MAX_HOLD, REQ[o]=1 and any other REQ bit is set, then release exactly as above.
    - The owner then has lowest priority at the next arbitration.
  - Otherwise GNT holds and HCNT increments, saturating at MAX_HOLD. With MAX_HOLD=0 it saturates at its maximum value.
  - HCNT width is max(1, clog2(MAX_HOLD+1)); with MAX_HOLD=0 use 1 bit, no limit applied.
  - Requests from non-owners never preempt except through the forced-release rule above.
- Wrap-around: PTR increments mod 4, so owner 3 releases to PTR=0.
- Simultaneous events:
  - Release and a new request on the same edge: the new request is arbitrated in the following IDLE cycle, not on the release edge.
  - Owner drops REQ on the same edge HCNT reaches MAX_HOLD: this is a normal release; the result is identical.
- Invariants:
  - GNT is always zero or one-hot.
  - BUSY == (GNT≠0).
  - GNT[i] is never newly asserted while REQ[i] was 0 at the deciding edge.

Test Plan:
- Reset: hold RST=1 for 2 cycles with REQ=4'b1111 -> GNT=0, BUSY=0, ANY=0, GNT_ID=0. After release, GNT=4'b0001 one cycle later, ANY=1 after one cycle.
- Round robin: hold REQ=4'b1111 with MAX_HOLD=8 -> GNT sequence 0001 (8 cycles), 0 (1 cycle), 0010, 0, 0100, 0, 1000, 0, 0001. GNT_ID follows 0,1,2,3,0.
- Normal release and priority: REQ=4'b0100 for 3 cycles then 4'b0001 -> GNT=0100 for 3 cycles, then 1 dead cycle, then GNT=0001. PTR=3 after the first release.
- Hold without contention: REQ=4'b1000 for 20 cycles, MAX_HOLD=8 -> GNT=1000 continuously for 20 cycles, no dead cycle. Then REQ=0 -> GNT=0 next cycle, PTR=0.
- Unlimited hold: MAX_HOLD=0, REQ=4'b0011 for 50 cycles -> GNT=0001 for all 50. Drop REQ[0] -> dead cycle, then GNT=0010.
- Reset mid-grant: grant on requester 2, assert RST for 1 cycle with REQ=4'b0110 -> GNT=0 on the reset edge. After reset, GNT=0010 (PTR reset to 0, scan finds bit 1).

Source files
------------

// File: rtl/or4_rr_grant.sv
// Round-robin return path for a 4-input OR request combiner: registered one-hot grant,
// owner index, busy flag and a registered copy of the combined request line.
module or4_rr_grant #(
  parameter int MAX_HOLD = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] GNT_ID,
  output logic       BUSY,
  output logic       ANY,
  output logic       o_dbg_state
);

  // Handshake: REQ[i] is a level request held until the requester is done; GNT[i]
  // is the registered answer, and dropping REQ[i] while granted releases the resource.

  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = (MAX_HOLD == 0) ? {HW{1'b1}} : HW'(MAX_HOLD);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_ptr, w_ptr_nxt;
  logic [HW-1:0] r_hcnt, w_hcnt_nxt;
  logic [3:0]    r_gnt, w_gnt_nxt;
  logic [1:0]    r_gnt_id, w_gnt_id_nxt;
  logic          r_any;

  logic [1:0]    w_winner;
  logic          w_found;
  logic          w_owner_req;
  logic          w_others;
  logic          w_force;
  logic          w_release;

  // Circular scan starting at the priority pointer.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && REQ[r_ptr + 2'(k)]) begin
        w_winner = r_ptr + 2'(k);
        w_found  = 1'b1;
      end
    end
  end

  assign w_owner_req = REQ[r_gnt_id];
  assign w_others    = |(REQ & ~r_gnt);
  assign w_force     = (MAX_HOLD != 0) && (r_hcnt == HMAX) && w_others;
  assign w_release   = !w_owner_req || w_force;

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_hcnt_nxt   = r_hcnt;
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt    = 4'b0001 << w_winner;
          w_gnt_id_nxt = w_winner;
          w_hcnt_nxt   = HW'(1);
          w_state_nxt  = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          // Releasing always costs one idle cycle before the next arbitration.
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_gnt_id + 2'd1;
          w_state_nxt = S_IDLE;
        end else if (r_hcnt != HMAX) begin
          w_hcnt_nxt = r_hcnt + HW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_hcnt   <= '0;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_any    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_hcnt   <= w_hcnt_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_any    <= |REQ;
    end
  end

  assign GNT         = r_gnt;
  assign GNT_ID      = r_gnt_id;
  assign BUSY        = |r_gnt;
  assign ANY         = r_any;
  assign o_dbg_state = (r_state == S_GRANT);

endmodule

// File: tb/tb_or4_rr_grant.sv
// Bench for or4_rr_grant: MAX_HOLD=8 and MAX_HOLD=0 instances share inputs and are
// compared every cycle against an owner/pointer/hold-count reference model.
module tb_or4_rr_grant;

  logic       clk;
  logic       rst;
  logic [3:0] req;

  logic [3:0] gnt_w [2];
  logic [1:0] id_w  [2];
  logic       busy_w[2];
  logic       any_w [2];
  logic       dbg_w [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] exp_q[$];

  int m_owner[2];
  int m_id   [2];
  int m_ptr  [2];
  int m_cnt  [2];
  int m_any  [2];
  int mh     [2] = '{8, 0};

  or4_rr_grant #(.MAX_HOLD(8)) u_dut8 (
    .CLK(clk), .RST(rst), .REQ(req),
    .GNT(gnt_w[0]), .GNT_ID(id_w[0]), .BUSY(busy_w[0]), .ANY(any_w[0]),
    .o_dbg_state(dbg_w[0])
  );

  or4_rr_grant #(.MAX_HOLD(0)) u_dut0 (
    .CLK(clk), .RST(rst), .REQ(req),
    .GNT(gnt_w[1]), .GNT_ID(id_w[1]), .BUSY(busy_w[1]), .ANY(any_w[1]),
    .o_dbg_state(dbg_w[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: who owns the resource, how long they have held it, who is next in line.
  task automatic model_step(input logic r, input logic [3:0] q);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_owner[k] = -1;
        m_id[k]    = 0;
        m_ptr[k]   = 0;
        m_cnt[k]   = 0;
        m_any[k]   = 0;
      end else begin
        m_any[k] = (q != 4'b0) ? 1 : 0;
        if (m_owner[k] < 0) begin
          for (int j = 0; j < 4; j++) begin
            int c;
            c = (m_ptr[k] + j) % 4;
            if (m_owner[k] < 0 && q[c]) begin
              m_owner[k] = c;
              m_id[k]    = c;
              m_cnt[k]   = 1;
            end
          end
        end else begin
          int  o;
          bit  others;
          o      = m_owner[k];
          others = (q & ~(4'b0001 << o)) != 4'b0;
          if (!q[o] || (mh[k] != 0 && m_cnt[k] == mh[k] && others)) begin
            m_ptr[k]   = (o + 1) % 4;
            m_owner[k] = -1;
          end else if (mh[k] != 0 && m_cnt[k] < mh[k]) begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
      exp_q.push_back(m_owner[k] < 0 ? 4'b0000 : (4'b0001 << m_owner[k]));
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [3:0] e_gnt;
      if (exp_q.size() == 0) begin
        e_gnt = 4'bxxxx;
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_empty%0d: got 0 entries expected 1", k);
      end else begin
        e_gnt = exp_q.pop_front();
        chk($sformatf("gnt%0d", k), 32'(gnt_w[k]), 32'(e_gnt));
      end
      chk($sformatf("gnt_id%0d", k), 32'(id_w[k]), 32'(m_id[k]));
      chk($sformatf("busy%0d", k), 32'(busy_w[k]), (m_owner[k] >= 0) ? 32'd1 : 32'd0);
      chk($sformatf("any%0d", k), 32'(any_w[k]), 32'(m_any[k]));
      chk($sformatf("state%0d", k), 32'(dbg_w[k]), (m_owner[k] >= 0) ? 32'd1 : 32'd0);
    end
  endtask

  // driver: apply inputs, let one edge happen, then check after the edge
  task automatic cycle(input logic r, input logic [3:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    model_step(r, q);
    #1;
    compare_all();
  endtask

  task automatic run(input logic r, input logic [3:0] q, input int n);
    for (int i = 0; i < n; i++) cycle(r, q);
  endtask

  initial begin
    logic [3:0] q;
    rst = 1'b1;
    req = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_id[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0; m_any[k] = 0;
    end
    @(negedge clk);

    // reset with all requesting, then release
    run(1'b1, 4'b1111, 2);
    // round robin under full contention (forced release on the MAX_HOLD=8 instance)
    run(1'b0, 4'b1111, 45);
    run(1'b0, 4'b0000, 2);
    // normal release and pointer advance
    run(1'b0, 4'b0100, 3);
    run(1'b0, 4'b0001, 4);
    run(1'b0, 4'b0000, 2);
    // sole requester never forced off
    run(1'b0, 4'b1000, 20);
    run(1'b0, 4'b0000, 2);
    // long contention: unlimited-hold instance keeps requester 0
    run(1'b0, 4'b0011, 50);
    run(1'b0, 4'b0010, 4);
    run(1'b0, 4'b0000, 2);
    // reset in the middle of a grant on requester 2
    run(1'b0, 4'b0100, 3);
    run(1'b1, 4'b0110, 1);
    run(1'b0, 4'b0110, 4);
    run(1'b0, 4'b0000, 1);

    // randomized: sticky request patterns with occasional reset
    q = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       q = 4'($urandom_range(0, 15));
        1:       q = q ^ (4'b0001 << $urandom_range(0, 3));
        2:       q = 4'b0000;
        default: q = q;
      endcase
      cycle($urandom_range(0, 199) == 0, q);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
